// File: rtl/csa_acumulador_seq.sv
// Multi-operand accumulator: keeps the running total as a carry-save pair so
// that each beat costs only one 3:2 compressor level, then resolves it with a
// single carry-propagate add when the group closes.
module csa_acumulador_seq #(
    parameter int N = 8,
    parameter int G = 4,
    localparam int W = N + G
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_data,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_soma,
    output logic           out_overflow,
    output logic [G:0]     out_count
);

    typedef enum logic [1:0] {ACC, RESOLVE, OUT} state_t;

    state_t         state;
    logic [W-1:0]   s, c;
    logic [G:0]     count;
    logic           ovf_sticky;

    logic [W-1:0]   x;
    logic [W-1:0]   s_next;
    logic [W-1:0]   maj;
    logic [W-1:0]   c_next;
    logic [W:0]     total;
    logic           beat;

    assign x      = W'(in_data);
    assign s_next = s ^ c ^ x;
    assign maj    = (s & c) | (s & x) | (c & x);
    assign c_next = {maj[W-2:0], 1'b0};
    assign total  = {1'b0, s} + {1'b0, c};

    // Handshake flags come straight from the state register.
    assign in_ready  = (state == ACC);
    assign out_valid = (state == OUT);
    assign beat      = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ACC;
            s            <= '0;
            c            <= '0;
            count        <= '0;
            ovf_sticky   <= 1'b0;
            out_soma     <= '0;
            out_overflow <= 1'b0;
            out_count    <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (beat) begin
                        s <= s_next;
                        c <= c_next;
                        // A majority bit at the top has weight 2^W and is lost.
                        if (maj[W-1])
                            ovf_sticky <= 1'b1;
                        if (count != '1)
                            count <= count + 1'b1;
                        if (in_last)
                            state <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    out_soma     <= total[W-1:0];
                    out_overflow <= total[W] | ovf_sticky;
                    out_count    <= count;
                    state        <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        s          <= '0;
                        c          <= '0;
                        count      <= '0;
                        ovf_sticky <= 1'b0;
                        state      <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_acumulador_seq.sv
// Directed bench for csa_acumulador_seq: an integer-sum reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_csa_acumulador_seq;

    localparam int N = 8;
    localparam int G = 4;
    localparam int W = N + G;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_data;
    logic           in_last;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_soma;
    logic           out_overflow;
    logic [G:0]     out_count;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    csa_acumulador_seq #(.N(N), .G(G)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_soma(out_soma),
        .out_overflow(out_overflow), .out_count(out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: exact integer group sum; phase 0 collect, 1 resolving, 2 presenting.
    int m_phase, m_sum, m_n, m_soma, m_ovf, m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_sum <= 0; m_n <= 0;
            m_soma  <= 0; m_ovf <= 0; m_cnt <= 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_sum <= m_sum + int'(in_data);
                    m_n   <= m_n + 1;
                    if (in_last) m_phase <= 1;
                end
                1: begin
                    m_soma  <= m_sum % (1 << W);
                    m_ovf   <= (m_sum >= (1 << W)) ? 1 : 0;
                    m_cnt   <= (m_n > (1 << (G + 1)) - 1) ? (1 << (G + 1)) - 1 : m_n;
                    m_phase <= 2;
                end
                default: if (out_ready) begin
                    m_sum <= 0; m_n <= 0; m_phase <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("mdl_in_ready",  32'(in_ready),     32'(m_phase == 0));
            chk("mdl_out_valid", 32'(out_valid),    32'(m_phase == 2));
            chk("mdl_soma",      32'(out_soma),     32'(m_soma));
            chk("mdl_overflow",  32'(out_overflow), 32'(m_ovf));
            chk("mdl_count",     32'(out_count),    32'(m_cnt));
        end
    end

    // Called at a negedge; returns at the negedge after the beat was taken.
    task automatic send(input logic [N-1:0] d, input logic l, output int waited);
        waited = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) chk("send_timeout", 32'(waited), 32'd0);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic get_result(input string name, input logic [W-1:0] es,
                              input logic eo, input logic [G:0] ec);
        int k = 0;
        out_ready = 1'b1;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_soma"},  32'(out_soma), 32'(es));
        chk({name, "_ovf"},   32'(out_overflow), 32'(eo));
        chk({name, "_count"}, 32'(out_count), 32'(ec));
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int w;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_soma",      32'(out_soma), 32'd0);
        chk("rst_count",     32'(out_count), 32'd0);
        chk("rst_ovf",       32'(out_overflow), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready), 32'd1);

        // 1: single operand, result appears one edge after acceptance
        send(8'hA5, 1'b1, w);
        chk("t1_resolve_not_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid_next", 32'(out_valid), 32'd1);
        get_result("t1", 12'h0A5, 1'b0, 5'd1);

        // 2: three 0xFF
        for (int i = 0; i < 3; i++) send(8'hFF, i == 2, w);
        get_result("t2", 12'h2FD, 1'b0, 5'd3);

        // 3: exactly 2^G operands, then one more to overflow
        for (int i = 0; i < 16; i++) send(8'hFF, i == 15, w);
        get_result("t3a", 12'hFF0, 1'b0, 5'd16);
        for (int i = 0; i < 17; i++) send(8'hFF, i == 16, w);
        get_result("t3b", 12'h0EF, 1'b1, 5'd17);

        // 4: backpressure with in_valid held high
        send(8'hFF, 1'b0, w);
        send(8'h24, 1'b1, w);
        in_valid = 1'b1; in_data = 8'h55;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_soma",  32'(out_soma), 32'h123);
            chk("t4_in_ready",   32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_ready_same_edge", 32'(in_ready), 32'd1);
        chk("t4_soma_kept",       32'(out_soma), 32'h123);
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);

        // 5: asynchronous reset mid-group
        send(8'h10, 1'b0, w);
        send(8'h20, 1'b0, w);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_soma_cleared",  32'(out_soma), 32'd0);
        chk("t5_valid_cleared", 32'(out_valid), 32'd0);
        chk("t5_count_cleared", 32'(out_count), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        send(8'h01, 1'b1, w);
        get_result("t5", 12'h001, 1'b0, 5'd1);

        // 6: back-to-back groups, consumer always ready
        out_ready = 1'b1;
        send(8'h01, 1'b0, w);
        send(8'h02, 1'b1, w);
        send(8'h80, 1'b1, w);
        chk("t6_dead_cycles", 32'(w), 32'd2);
        chk("t6_first_kept",  32'(out_soma), 32'h003);
        @(negedge clk);
        chk("t6_second_valid", 32'(out_valid), 32'd1);
        chk("t6_second_soma",  32'(out_soma), 32'h080);
        @(negedge clk);
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
